// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants, op codes and FSM encoding for ram_ctrl
// Purpose: single source for the RAM geometry (AW/DW), command op codes and
//          the controller state encoding, plus the length-to-count helper.
// Ports:   none (package).
package ram_pkg;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = AW + 1;  // remaining-word counter, holds 1..32

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_FILL = 2'b01,
    OP_WINC = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_RD_REQ = 3'd2,
    S_RD_CAP = 3'd3,
    S_RSP    = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  // A length of zero means a full-depth burst of 2^AW words.
  function automatic logic [CW-1:0] len_to_cnt(input logic [AW-1:0] len);
    return (len == '0) ? CW'(1 << AW) : {1'b0, len};
  endfunction

endpackage

// File: rtl/ram_ctrl_if.sv
// rtl/ram_ctrl_if.sv - command / response bundle between host and ram_ctrl
// Purpose: groups the command handshake, read-response handshake and the
//          done/err completion pulses.
// Ports:   master = host side (drives cmd_*, rsp_ready)
//          slave  = controller side (drives cmd_ready, rsp_*, done, err)
interface ram_ctrl_if
  import ram_pkg::*;
  ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic [DW-1:0] cmd_data;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;

  logic          done;
  logic          err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_last, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_last, done, err
  );

endinterface

// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - command-driven burst initiator for a 32x32 sync RAM
// Purpose: accepts READ / FILL / WRITE_INC bursts, drives the RAM pins and
//          returns read words over a valid/ready response channel.
// Ports:   clk, rst      clock, async active-high reset
//          bus (slave)   command / response / done / err bundle
//          ram_cen/wen   RAM chip / write enable
//          ram_addr/din  RAM address / write data
//          ram_dout      RAM read data, valid the cycle after a read strobe
module ram_ctrl
  import ram_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  ram_ctrl_if.slave     bus,
  output logic          ram_cen,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic          winc_q, winc_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          rsp_last_q, rsp_last_d;
  logic          done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      winc_q     <= 1'b0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      winc_q     <= winc_d;
      rsp_data_q <= rsp_data_d;
      rsp_last_q <= rsp_last_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    winc_d     = winc_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d = bus.cmd_addr;
          cnt_d  = len_to_cnt(bus.cmd_len);
          data_d = bus.cmd_data;
          winc_d = (bus.cmd_op == OP_WINC);
          case (bus.cmd_op)
            OP_READ: state_d = S_RD_REQ;
            OP_FILL: state_d = S_WR;
            OP_WINC: state_d = S_WR;
            default: state_d = S_ERR;
          endcase
        end
      end
      S_WR: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q - 1'b1;
        if (winc_q) data_d = data_q + 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_RD_REQ: state_d = S_RD_CAP;
      S_RD_CAP: begin
        rsp_data_d = ram_dout;
        rsp_last_d = (cnt_q == CW'(1));
        state_d    = S_RSP;
      end
      S_RSP: begin
        if (bus.rsp_ready) begin
          if (rsp_last_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q - 1'b1;
            state_d = S_RD_REQ;
          end
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // RAM pins decode from state and registers only; rst gating makes the
  // strobe drop in the same instant the reset arrives.
  always_comb begin
    ram_cen  = 1'b0;
    ram_wen  = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (!rst) begin
      if (state_q == S_WR) begin
        ram_cen  = 1'b1;
        ram_wen  = 1'b1;
        ram_addr = addr_q;
        ram_din  = data_q;
      end else if (state_q == S_RD_REQ) begin
        ram_cen  = 1'b1;
        ram_addr = addr_q;
      end
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE) && !rst;
  assign bus.rsp_valid = (state_q == S_RSP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.done      = done_q || (state_q == S_ERR);
  assign bus.err       = (state_q == S_ERR);

endmodule
